// File: rtl/xgmii_pkg.sv
// Shared XGMII character constants, canned words and framer state type.
// Used by the transmit framer and the terminate-insertion helper.
package xgmii_pkg;

    // XGMII control characters
    localparam logic [7:0] XGMII_IDLE    = 8'h07;
    localparam logic [7:0] XGMII_START   = 8'hFB;
    localparam logic [7:0] XGMII_TERM    = 8'hFD;
    localparam logic [7:0] XGMII_ERROR   = 8'hFE;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD           = 8'hD5;

    // All eight lanes idle
    localparam logic [63:0] IDLE_WORD = {8{XGMII_IDLE}};
    localparam logic [7:0]  IDLE_TXC  = 8'hFF;

    // Start in lane 0, six preamble bytes, SFD in lane 7
    localparam logic [63:0] PREAMBLE_WORD = {SFD, {6{PREAMBLE_BYTE}}, XGMII_START};
    localparam logic [7:0]  PREAMBLE_TXC  = 8'h01;

    // Terminate in lane 0 after a frame whose last word was completely full
    localparam logic [63:0] TERM_WORD = {{7{XGMII_IDLE}}, XGMII_TERM};
    localparam logic [7:0]  TERM_TXC  = 8'hFF;

    // Error then terminate, used to poison a frame the client starved
    localparam logic [63:0] UNDERRUN_WORD = {{6{XGMII_IDLE}}, XGMII_TERM, XGMII_ERROR};
    localparam logic [7:0]  UNDERRUN_TXC  = 8'hFF;

    // Idle-lane counts of the two canned terminating words
    localparam logic [3:0] TERM_IDLE_LANES     = 4'd7;
    localparam logic [3:0] UNDERRUN_IDLE_LANES = 4'd6;

    // Gap counter holds up to ceil(64/8) = 8 idle words
    localparam int IFG_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TERM = 2'd2,
        IFG  = 2'd3
    } tx_state_t;

    // Whole idle words still owed after a terminating word that already
    // carried idleLanes idle bytes; rounds up so the gap is never short.
    function automatic logic [IFG_CNT_W-1:0] calcIfgWords(input int unsigned ifgBytes,
                                                          input logic [3:0] idleLanes);
        int unsigned remaining;
        remaining = (ifgBytes > 32'(idleLanes)) ? (ifgBytes - 32'(idleLanes)) : 32'd0;
        return IFG_CNT_W'((remaining + 32'd7) / 32'd8);
    endfunction

endpackage

// File: rtl/xgmii_term_insert.sv
// Merges a terminate character into a partially filled data word.
// Lanes below n keep data, lane n gets the terminate, lanes above n go idle.
// Also reports how many idle lanes the merged word carries.
module xgmii_term_insert
    import xgmii_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [2:0]  i_n,
    output logic [63:0] o_txd,
    output logic [7:0]  o_txc,
    output logic [3:0]  o_idle_lanes
);

    // Per-lane select between client data, terminate and idle
    always_comb begin
        o_txd = IDLE_WORD;
        o_txc = IDLE_TXC;
        for (int lane = 0; lane < 8; lane++) begin
            if (3'(lane) < i_n) begin
                o_txd[8*lane +: 8] = i_data[8*lane +: 8];
                o_txc[lane]        = 1'b0;
            end else if (3'(lane) == i_n) begin
                o_txd[8*lane +: 8] = XGMII_TERM;
                o_txc[lane]        = 1'b1;
            end else begin
                o_txd[8*lane +: 8] = XGMII_IDLE;
                o_txc[lane]        = 1'b1;
            end
        end
        o_idle_lanes = 4'd7 - {1'b0, i_n};
    end

endmodule

// File: rtl/xgmii_tx_framer.sv
// Client-side XGMII transmit framer.
// Wraps a 64-bit client word stream into XGMII frames: preamble/SFD on the
// way in, terminate (or error+terminate on underrun) on the way out, then
// enough idle words to honour the minimum inter-frame gap.
// The client supplies the FCS; nothing here touches CRC.
module xgmii_tx_framer
    import xgmii_pkg::*;
#(
    parameter int IFG_BYTES      = 12,
    parameter int FRAME_CNT_W    = 32,
    parameter int UNDERRUN_CNT_W = 16
)(
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_link_up,
    input  logic [63:0]               i_tx_data,
    input  logic                      i_tx_valid,
    input  logic                      i_tx_end,
    input  logic [2:0]                i_tx_bytes,
    output logic                      o_tx_ready,
    output logic [63:0]               o_xgmii_txd,
    output logic [7:0]                o_xgmii_txc,
    output logic [FRAME_CNT_W-1:0]    o_frame_count,
    output logic [UNDERRUN_CNT_W-1:0] o_underrun_count
);

    // Gaps owed after the two canned terminating words are fixed per build
    localparam logic [IFG_CNT_W-1:0] GAP_AFTER_TERM =
        calcIfgWords($unsigned(IFG_BYTES), TERM_IDLE_LANES);
    localparam logic [IFG_CNT_W-1:0] GAP_AFTER_UNDERRUN =
        calcIfgWords($unsigned(IFG_BYTES), UNDERRUN_IDLE_LANES);

    tx_state_t                 r_state;
    logic [IFG_CNT_W-1:0]      r_ifgCnt;
    logic [63:0]               r_txd;
    logic [7:0]                r_txc;
    logic [FRAME_CNT_W-1:0]    r_frameCount;
    logic [UNDERRUN_CNT_W-1:0] r_underrunCount;

    logic [63:0]          w_termTxd;
    logic [7:0]           w_termTxc;
    logic [3:0]           w_termIdleLanes;
    logic [IFG_CNT_W-1:0] w_gapPartial;

    // Terminate merge for a short last word; only meaningful when tx_bytes != 0
    xgmii_term_insert u_term_insert (
        .i_data       (i_tx_data),
        .i_n          (i_tx_bytes),
        .o_txd        (w_termTxd),
        .o_txc        (w_termTxc),
        .o_idle_lanes (w_termIdleLanes)
    );

    assign w_gapPartial = calcIfgWords($unsigned(IFG_BYTES), w_termIdleLanes);

    // Frame sequencing, registered XGMII outputs and statistics counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_ifgCnt        <= '0;
            r_txd           <= IDLE_WORD;
            r_txc           <= IDLE_TXC;
            r_frameCount    <= '0;
            r_underrunCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_tx_valid && i_link_up && (r_ifgCnt == '0)) begin
                        r_txd   <= PREAMBLE_WORD;
                        r_txc   <= PREAMBLE_TXC;
                        r_state <= DATA;
                    end else begin
                        r_txd <= IDLE_WORD;
                        r_txc <= IDLE_TXC;
                    end
                end

                DATA: begin
                    if (!i_tx_valid) begin
                        r_txd    <= UNDERRUN_WORD;
                        r_txc    <= UNDERRUN_TXC;
                        r_ifgCnt <= GAP_AFTER_UNDERRUN;
                        r_state  <= (GAP_AFTER_UNDERRUN == '0) ? IDLE : IFG;
                        if (r_underrunCount != '1) begin
                            r_underrunCount <= r_underrunCount + UNDERRUN_CNT_W'(1);
                        end
                    end else if (!i_tx_end) begin
                        r_txd <= i_tx_data;
                        r_txc <= 8'h00;
                    end else if (i_tx_bytes == 3'd0) begin
                        r_txd   <= i_tx_data;
                        r_txc   <= 8'h00;
                        r_state <= TERM;
                    end else begin
                        r_txd        <= w_termTxd;
                        r_txc        <= w_termTxc;
                        r_frameCount <= r_frameCount + FRAME_CNT_W'(1);
                        r_ifgCnt     <= w_gapPartial;
                        r_state      <= (w_gapPartial == '0) ? IDLE : IFG;
                    end
                end

                TERM: begin
                    r_txd        <= TERM_WORD;
                    r_txc        <= TERM_TXC;
                    r_frameCount <= r_frameCount + FRAME_CNT_W'(1);
                    r_ifgCnt     <= GAP_AFTER_TERM;
                    r_state      <= (GAP_AFTER_TERM == '0) ? IDLE : IFG;
                end

                IFG: begin
                    r_txd <= IDLE_WORD;
                    r_txc <= IDLE_TXC;
                    if (r_ifgCnt <= IFG_CNT_W'(1)) begin
                        r_ifgCnt <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_ifgCnt <= r_ifgCnt - IFG_CNT_W'(1);
                    end
                end

                default: begin
                    r_txd    <= IDLE_WORD;
                    r_txc    <= IDLE_TXC;
                    r_ifgCnt <= '0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    // Ready is a plain decode of the state register so the client never
    // sees a combinational loop through tx_valid
    assign o_tx_ready       = (r_state == DATA);
    assign o_xgmii_txd      = r_txd;
    assign o_xgmii_txc      = r_txc;
    assign o_frame_count    = r_frameCount;
    assign o_underrun_count = r_underrunCount;

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Testbench for xgmii_tx_framer.
// Stimulus runs cycle by cycle and queues the XGMII word expected after each
// edge; a monitor pops and compares every cycle. A second instance built
// with IFG_BYTES=0 covers the zero-gap case.
module tb_xgmii_tx_framer;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W = 64'h07070707070707FD;
    localparam logic [63:0] UND_W  = 64'h070707070707FDFE;

    typedef struct packed {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        rdy;
    } exp_t;

    logic clk;
    logic reset;

    logic        linkUp,  txValid,  txEnd,  txReady;
    logic [2:0]  txBytes;
    logic [63:0] txData,  txd;
    logic [7:0]  txc;
    logic [31:0] frameCount;
    logic [15:0] underrunCount;

    logic        linkUp0, txValid0, txEnd0, txReady0;
    logic [2:0]  txBytes0;
    logic [63:0] txData0, txd0;
    logic [7:0]  txc0;
    logic [31:0] frameCount0;
    logic [15:0] underrunCount0;

    exp_t expQ[$];
    exp_t expQ0[$];
    int   nCompared;
    int   nMismatched;
    int   wordId;
    int   wordId0;

    xgmii_tx_framer u_dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_link_up        (linkUp),
        .i_tx_data        (txData),
        .i_tx_valid       (txValid),
        .i_tx_end         (txEnd),
        .i_tx_bytes       (txBytes),
        .o_tx_ready       (txReady),
        .o_xgmii_txd      (txd),
        .o_xgmii_txc      (txc),
        .o_frame_count    (frameCount),
        .o_underrun_count (underrunCount)
    );

    xgmii_tx_framer #(.IFG_BYTES(0)) u_dut0 (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_link_up        (linkUp0),
        .i_tx_data        (txData0),
        .i_tx_valid       (txValid0),
        .i_tx_end         (txEnd0),
        .i_tx_bytes       (txBytes0),
        .o_tx_ready       (txReady0),
        .o_xgmii_txd      (txd0),
        .o_xgmii_txc      (txc0),
        .o_frame_count    (frameCount0),
        .o_underrun_count (underrunCount0)
    );

    // Free-running XGMII clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Client word w of a frame: byte b carries seed + 8*w + b
    function automatic logic [63:0] dataWord(input logic [7:0] seed, input int w);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = seed + 8'(8*w + b);
        end
        return r;
    endfunction

    task automatic compareWord(input int dut, input int id, input exp_t e,
                               input logic [63:0] aTxd, input logic [7:0] aTxc, input logic aRdy);
        nCompared++;
        if (aTxd !== e.txd || aTxc !== e.txc || aRdy !== e.rdy) begin
            nMismatched++;
            $display("[TB] FAIL dut%0d word%0d: got txd=%h txc=%h rdy=%b, expected txd=%h txc=%h rdy=%b",
                     dut, id, aTxd, aTxc, aRdy, e.txd, e.txc, e.rdy);
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of client inputs on the falling edge and queue the
    // word that should appear after the following rising edge
    task automatic applyStimulus(input bit sel, input logic link, input logic valid,
                                 input logic last, input logic [2:0] bytes,
                                 input logic [63:0] data, input logic [63:0] eTxd,
                                 input logic [7:0] eTxc, input logic eRdy);
        exp_t item;
        @(negedge clk);
        item.txd = eTxd;
        item.txc = eTxc;
        item.rdy = eRdy;
        if (!sel) begin
            linkUp  = link;
            txValid = valid;
            txEnd   = last;
            txBytes = bytes;
            txData  = data;
            expQ.push_back(item);
        end else begin
            linkUp0  = link;
            txValid0 = valid;
            txEnd0   = last;
            txBytes0 = bytes;
            txData0  = data;
            expQ0.push_back(item);
        end
    endtask

    task automatic idleCycle(input bit sel, input logic link, input logic valid,
                             input logic [63:0] data);
        applyStimulus(sel, link, valid, 1'b0, 3'd0, data, IDLE_W, 8'hFF, 1'b0);
    endtask

    // Preamble cycle followed by nWords client words; the final word's
    // expected XGMII image is supplied by the caller
    task automatic sendFrame(input bit sel, input logic [7:0] seed, input int nWords,
                             input logic [2:0] lastBytes, input logic [63:0] lastTxd,
                             input logic [7:0] lastTxc, input bit dropLink);
        applyStimulus(sel, 1'b1, 1'b1, 1'b0, 3'd0, dataWord(seed, 0), PRE_W, 8'h01, 1'b1);
        for (int w = 0; w < nWords; w++) begin
            if (w < nWords - 1) begin
                applyStimulus(sel, !(dropLink && w > 0), 1'b1, 1'b0, 3'd3,
                              dataWord(seed, w), dataWord(seed, w), 8'h00, 1'b1);
            end else begin
                applyStimulus(sel, !(dropLink && w > 0), 1'b1, 1'b1, lastBytes,
                              dataWord(seed, w), lastTxd, lastTxc, 1'b0);
            end
        end
    endtask

    // Scoreboard monitor: one expected word per queued cycle per instance
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            compareWord(12, wordId, e, txd, txc, txReady);
            wordId++;
        end
        if (expQ0.size() > 0) begin
            e = expQ0.pop_front();
            compareWord(0, wordId0, e, txd0, txc0, txReady0);
            wordId0++;
        end
    end

    // Directed sequence
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        wordId      = 0;
        wordId0     = 0;
        reset    = 1'b1;
        linkUp   = 1'b0; txValid  = 1'b0; txEnd  = 1'b0; txBytes  = 3'd0; txData  = '0;
        linkUp0  = 1'b0; txValid0 = 1'b0; txEnd0 = 1'b0; txBytes0 = 3'd0; txData0 = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_txd",      txd,           IDLE_W);
        checkOutput("reset_txc",      64'(txc),      64'hFF);
        checkOutput("reset_ready",    64'(txReady),  64'h0);
        checkOutput("reset_frames",   64'(frameCount),    64'h0);
        checkOutput("reset_underrun", 64'(underrunCount), 64'h0);
        checkOutput("reset_txd_ifg0", txd0,          IDLE_W);
        reset = 1'b0;

        // Link down: client asks to send, framer keeps idling
        repeat (3) idleCycle(0, 1'b0, 1'b1, dataWord(8'h80, 0));
        // tx_end without tx_valid is not a frame
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 3'd5, dataWord(8'h80, 0), IDLE_W, 8'hFF, 1'b0);

        // 64-byte frame: full last word, separate TERM word, one idle
        sendFrame(0, 8'h80, 8, 3'd0, dataWord(8'h80, 7), 8'h00, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, dataWord(8'h00, 0), TERM_W, 8'hFF, 1'b0);
        idleCycle(0, 1'b1, 1'b1, dataWord(8'h00, 0));
        checkOutput("frames_after_64B", 64'(frameCount), 64'd1);

        // 61-byte frame starts two cycles after TERM, then back-to-back
        // 61-byte frame with valid held and link dropping mid-frame
        sendFrame(0, 8'h00, 8, 3'd5, 64'h0707FD3C3B3A3938, 8'hE0, 1'b0);
        idleCycle(0, 1'b1, 1'b1, dataWord(8'h40, 0));
        checkOutput("frames_after_61B", 64'(frameCount), 64'd2);
        idleCycle(0, 1'b1, 1'b1, dataWord(8'h40, 0));
        sendFrame(0, 8'h40, 8, 3'd5, 64'h0707FD7C7B7A7978, 8'hE0, 1'b1);
        idleCycle(0, 1'b1, 1'b0, 64'h0);
        checkOutput("frames_after_b2b", 64'(frameCount), 64'd3);
        idleCycle(0, 1'b1, 1'b0, 64'h0);

        // Underrun after three data words, one idle, then a good frame
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, dataWord(8'h20, 0), PRE_W, 8'h01, 1'b1);
        for (int w = 0; w < 3; w++) begin
            applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd2, dataWord(8'h20, w),
                          dataWord(8'h20, w), 8'h00, 1'b1);
        end
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 3'd0, 64'h0, UND_W, 8'hFF, 1'b0);
        idleCycle(0, 1'b1, 1'b1, dataWord(8'hC0, 0));
        checkOutput("underruns_after_abort", 64'(underrunCount), 64'd1);
        checkOutput("frames_after_abort",    64'(frameCount),    64'd3);
        sendFrame(0, 8'hC0, 8, 3'd5, 64'h0707FDFCFBFAF9F8, 8'hE0, 1'b0);
        idleCycle(0, 1'b1, 1'b0, 64'h0);
        checkOutput("frames_after_recovery", 64'(frameCount), 64'd4);
        idleCycle(0, 1'b1, 1'b0, 64'h0);

        // Reset in the middle of a frame: idle out, no terminate, counters clear
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, dataWord(8'h10, 0), PRE_W, 8'h01, 1'b1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, dataWord(8'h10, 0), dataWord(8'h10, 0), 8'h00, 1'b1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, dataWord(8'h10, 1), dataWord(8'h10, 1), 8'h00, 1'b1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd0, dataWord(8'h10, 2), IDLE_W, 8'hFF, 1'b0);
        reset = 1'b1;
        idleCycle(0, 1'b1, 1'b0, 64'h0);
        checkOutput("frames_after_reset",    64'(frameCount),    64'd0);
        checkOutput("underruns_after_reset", 64'(underrunCount), 64'd0);
        reset = 1'b0;
        sendFrame(0, 8'h00, 1, 3'd5, 64'h0707FD0403020100, 8'hE0, 1'b0);
        idleCycle(0, 1'b1, 1'b0, 64'h0);
        checkOutput("frames_single_word", 64'(frameCount), 64'd1);

        // Zero-gap build: preamble directly after TERM and after a short last word
        sendFrame(1, 8'h80, 8, 3'd0, dataWord(8'h80, 7), 8'h00, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd0, dataWord(8'h00, 0), TERM_W, 8'hFF, 1'b0);
        sendFrame(1, 8'h00, 8, 3'd5, 64'h0707FD3C3B3A3938, 8'hE0, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd0, dataWord(8'h40, 0), PRE_W, 8'h01, 1'b1);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0, UND_W, 8'hFF, 1'b0);
        idleCycle(1, 1'b1, 1'b0, 64'h0);
        checkOutput("ifg0_frames",    64'(frameCount0),    64'd2);
        checkOutput("ifg0_underruns", 64'(underrunCount0), 64'd1);

        // Let the monitor drain; anything left over is a failure
        repeat (4) @(posedge clk);
        #2;
        if (expQ.size() != 0 || expQ0.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL drain: %0d/%0d words left, expected 0/0", expQ.size(), expQ0.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/xgmii_tx_framer.md
Name: xgmii_tx_framer

Overview:
- Client-side XGMII transmit framer that drives xgmii_txd/xgmii_txc of the XAUI PHY wrapper.
- Converts a 64-bit word-stream client interface into XGMII frames: start/preamble/SFD insertion, terminate insertion, underrun abort and minimum inter-frame gap.
- Client supplies the complete frame including FCS; the block computes no CRC.
- Sits between the packet TX buffer and the XAUI PHY, in the PHY clock domain.

Parameters:
- IFG_BYTES, 12, minimum idle bytes between a terminate character and the next start; legal range 0..64.
- FRAME_CNT_W, 32, width of the frame counter.
- UNDERRUN_CNT_W, 16, width of the underrun counter.

Ports:
- clk  in  1  XGMII clock (156.25 MHz).
- reset  in  1  synchronous, active-high.
- link_up  in  1  link status from the PHY status vector; sampled only at frame start.
- tx_data  in  64  client word; byte 0 in bits [7:0], transmitted first.
- tx_valid  in  1  word valid.
- tx_end  in  1  last word of frame; qualified by tx_valid.
- tx_bytes  in  3  valid bytes in the last word; 0 means 8; lanes 0..n-1 are valid.
- tx_ready  out  1  word accepted when tx_valid && tx_ready.
- xgmii_txd  out  64  XGMII data; lane i = [8i+7:8i].
- xgmii_txc  out  8  XGMII control; bit i flags lane i.
- frame_count  out  FRAME_CNT_W  frames completed normally; wraps.
- underrun_count  out  UNDERRUN_CNT_W  frames aborted; saturates at all-ones.

Behaviour:
- Reset values: xgmii_txd=0x0707070707070707, xgmii_txc=0xFF, tx_ready=0, both counters 0, state IDLE, IFG satisfied.
- All XGMII outputs are registered. Output word N appears on the clock edge after the cycle that decides it.
- tx_ready = (state==DATA). It is a registered state decode with no combinational path from tx_valid.
- IDLE state:
  - Emit the idle word.
  - If tx_valid && link_up && ifg_cnt==0: emit the preamble word (txd=0xD5555555555555FB, txc=0x01) and go to DATA.
  - The first data word is not consumed in this cycle; the client holds it.
  - If link_up=0: stay in IDLE emitting idles. tx_valid is ignored.
- DATA state with tx_valid=1 and tx_end=0: emit tx_data with txc=0x00.
- DATA state with tx_valid=1 and tx_end=1, n=tx_bytes (0 means 8):
  - n<8: lanes 0..n-1 carry data (c=0), lane n carries 0xFD (c=1), lanes >n carry 0x07 (c=1). frame_count+1. Go to IFG.
  - n=8: emit full data word (txc=0x00) and go to TERM.
- TERM state: emit 0x07070707070707FD, txc=0xFF. frame_count+1. Go to IFG.
- DATA state with tx_valid=0 (underrun):
  - Emit txd=0x070707070707FDFE, txc=0xFF (error, terminate, idles).
  - underrun_count+1. Go to IFG. The frame is not counted in frame_count.
- IFG accounting:
  - k = number of 0x07 lanes in the terminating word.
  - r = max(0, IFG_BYTES-k).
  - Load ifg_cnt=ceil(r/8) idle words on entering IFG.
  - IFG state emits idle words and decrements ifg_cnt; when it reaches 0, go to IDLE.
  - Entering IFG with ifg_cnt=0 goes straight to IDLE next cycle. That cycle emits the idle word. The earliest next preamble is the cycle after the terminating word.
- link_up falling mid-frame has no effect; the frame completes or underruns normally.
- reset asserted mid-frame: the next output is the idle word, with no terminate emitted. Counters clear.
- tx_end=1 with tx_valid=0: ignored.
- tx_bytes is ignored unless tx_end=1.
- Start character is only ever placed in lane 0.

Decomposition:
- Package xgmii_pkg holds:
  - constants XGMII_IDLE=0x07, XGMII_START=0xFB, XGMII_TERM=0xFD, XGMII_ERROR=0xFE, PREAMBLE_BYTE=0x55, SFD=0xD5;
  - IDLE_WORD and PREAMBLE_WORD (64-bit) with their txc values;
  - the state enumeration {IDLE, DATA, TERM, IFG}.
- Sub-module xgmii_term_insert is combinational. It takes data and n=1..7 and returns the merged txd/txc plus the idle-lane count k. It is reused by the future RX checker model.

Test Plan:
- 64-byte frame: 8 words, last tx_bytes=0 -> preamble word, 8 data words txc=0x00, then TERM word 0x07070707070707FD/0xFF (k=7, r=5), 1 idle word, earliest next preamble 2 cycles after TERM word; frame_count=1.
- 61-byte frame: last tx_bytes=5 -> last word lanes0-4 data, lane5=0xFD, lanes6-7=0x07, txc=0xE0; k=2, r=10, 2 idle words before next start.
- Back-to-back 61-byte frames with tx_valid held high -> exactly 2 idle words between frames; tx_ready low during preamble and IFG; no data lost or duplicated.
- Underrun: tx_valid dropped after 3 data words -> 0x070707070707FDFE/0xFF, underrun_count=1, frame_count unchanged, 1 idle word (k=6, r=6), then normal frame accepted.
- link_up=0 with tx_valid=1 -> continuous idle words, tx_ready=0; raise link_up -> preamble next cycle.
- Reset pulse in the middle of the DATA state -> next output idle word, counters 0; IFG_BYTES=0 build -> TERM word followed by a preamble after a single IDLE cycle.
